// File: rtl/video_pkg.sv
// +-----------------------------------------------------------------------------+
// | video_pkg : shared types and constants for the pixel stream packer          |
// | Rev 1.0   : initial release                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

package video_pkg;

  localparam int DEFAULT_RGB_SIZE      = 24;
  localparam int DEFAULT_SCREEN_WIDTH  = 640;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;
  localparam int DEFAULT_CNT_WIDTH     = 32;

  typedef struct packed {
    logic [DEFAULT_RGB_SIZE-1:0] colour;
    logic                        sop;
    logic                        eop;
  } pix_beat_t;

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } packer_state_e;

  localparam int ERR_W             = 3;
  localparam int ERR_ORPHAN        = 0;
  localparam int ERR_EARLY_FIRST   = 1;
  localparam int ERR_FLAG_MISMATCH = 2;

  localparam int DROP_W = 16;

endpackage : video_pkg

`default_nettype wire

// File: rtl/stream_skid_buffer.sv
// +-----------------------------------------------------------------------------+
// | stream_skid_buffer : 2-entry valid/ready buffer with a registered in_ready  |
// | Rev 1.0            : initial release                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module stream_skid_buffer
  import video_pkg::*;
#(
  parameter int DATA_W = $bits(pix_beat_t)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic              wr_en;
  logic              rd_en;

  assign wr_en     = in_valid && ready_q;
  assign rd_en     = (count_q != 2'd0) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Ready looks one cycle ahead so it can come straight from a flop.
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= in_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

endmodule : stream_skid_buffer

`default_nettype wire

// File: rtl/pixel_stream_packer.sv
// +-----------------------------------------------------------------------------+
// | pixel_stream_packer : re-frames pixel beats into an sop/eop video packet    |
// | Rev 1.0             : initial release                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pixel_stream_packer
  import video_pkg::*;
#(
  parameter int RGB_SIZE      = DEFAULT_RGB_SIZE,
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RGB_SIZE-1:0] in_colour,
  input  logic                in_first,
  input  logic                in_last_x,
  input  logic                in_last_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RGB_SIZE-1:0] out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic                frame_done,
  output logic [ERR_W-1:0]    err_flags,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int                   BEAT_W       = RGB_SIZE + 2;
  localparam logic [CNT_WIDTH-1:0] X_LAST       = CNT_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST       = CNT_WIDTH'(SCREEN_HEIGHT - 1);
  localparam longint unsigned      FRAME_PIXELS = longint'(SCREEN_WIDTH) * longint'(SCREEN_HEIGHT);

  generate
    if ((CNT_WIDTH < 64) && (FRAME_PIXELS > (64'd1 << CNT_WIDTH))) begin : g_size_check
      $error("pixel_stream_packer: SCREEN_WIDTH*SCREEN_HEIGHT does not fit in CNT_WIDTH");
    end
  endgenerate

  packer_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] xcnt_q, xcnt_d;
  logic [CNT_WIDTH-1:0] ycnt_q, ycnt_d;
  logic [CNT_WIDTH-1:0] pos_x, pos_y;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 frame_done_q;

  logic                 accept;
  logic                 fwd;
  logic                 beat_sop;
  logic                 beat_eop;
  logic                 pos_x_last;
  logic                 pos_frame_last;
  logic                 skid_in_ready;
  logic                 skid_out_valid;
  logic [BEAT_W-1:0]    skid_out_data;

  assign accept = in_valid && skid_in_ready;

  always_comb begin
    state_d  = state_q;
    xcnt_d   = xcnt_q;
    ycnt_d   = ycnt_q;
    err_d    = err_q;
    drop_d   = drop_q;
    fwd      = 1'b0;
    beat_sop = 1'b0;
    beat_eop = 1'b0;

    // In SYNC the next forwarded beat can only be the frame origin.
    pos_x          = (state_q == ACTIVE) ? xcnt_q : '0;
    pos_y          = (state_q == ACTIVE) ? ycnt_q : '0;
    pos_x_last     = (pos_x == X_LAST);
    pos_frame_last = pos_x_last && (pos_y == Y_LAST);

    if (accept) begin
      if ((state_q == SYNC) && !in_first) begin
        err_d[ERR_ORPHAN] = 1'b1;
        if (drop_q != {DROP_W{1'b1}}) begin
          drop_d = drop_q + DROP_W'(1);
        end
      end else if ((state_q == ACTIVE) && in_first) begin
        err_d[ERR_EARLY_FIRST] = 1'b1;
        xcnt_d                 = '0;
        ycnt_d                 = '0;
        state_d                = SYNC;
      end else begin
        fwd      = 1'b1;
        beat_sop = (state_q == SYNC);
        beat_eop = pos_frame_last;
        if ((in_last_x != pos_x_last) || (in_last_y != pos_frame_last)) begin
          err_d[ERR_FLAG_MISMATCH] = 1'b1;
        end
        if (pos_frame_last) begin
          xcnt_d  = '0;
          ycnt_d  = '0;
          state_d = SYNC;
        end else if (pos_x_last) begin
          xcnt_d  = '0;
          ycnt_d  = pos_y + CNT_WIDTH'(1);
          state_d = ACTIVE;
        end else begin
          xcnt_d  = pos_x + CNT_WIDTH'(1);
          ycnt_d  = pos_y;
          state_d = ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SYNC;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      err_q        <= '0;
      drop_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      frame_done_q <= skid_out_valid && out_ready && skid_out_data[0];
    end
  end

  stream_skid_buffer #(
    .DATA_W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (accept && fwd),
    .in_ready  (skid_in_ready),
    .in_data   ({in_colour, beat_sop, beat_eop}),
    .out_valid (skid_out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out_data)
  );

  assign in_ready   = skid_in_ready;
  assign out_valid  = skid_out_valid;
  assign out_data   = skid_out_data[BEAT_W-1:2];
  assign out_sop    = skid_out_data[1];
  assign out_eop    = skid_out_data[0];
  assign frame_done = frame_done_q;
  assign err_flags  = err_q;
  assign drop_count = drop_q;

endmodule : pixel_stream_packer

`default_nettype wire

// File: tb/tb_pixel_stream_packer.sv
// +-----------------------------------------------------------------------------+
// | tb_pixel_stream_packer : randomized bench against a pixel-index reference   |
// | Rev 1.0                : initial release                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_pixel_stream_packer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int NPX = W * H;

  typedef struct packed {
    logic [23:0] colour;
    logic        first;
    logic        lx;
    logic        ly;
  } stim_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_colour;
  logic        in_first;
  logic        in_last_x;
  logic        in_last_y;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        frame_done;
  logic [2:0]  err_flags;
  logic [15:0] drop_count;

  pixel_stream_packer #(
    .RGB_SIZE      (24),
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .CNT_WIDTH     (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_colour  (in_colour),
    .in_first   (in_first),
    .in_last_x  (in_last_x),
    .in_last_y  (in_last_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .frame_done (frame_done),
    .err_flags  (err_flags),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a linear pixel index 0..NPX-1.
  stim_t       stim_q[$];
  logic [25:0] exp_q[$];
  bit          m_synced;
  int          m_pos;
  logic [2:0]  m_err;
  int          m_drop;
  bit          fd_pending;
  bit          stalled;
  logic [25:0] held;
  int          frames_seen;
  int          accepts;
  int          cycles;
  bit          gaps;
  int          or_mode;
  logic [3:0]  or_pat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic flag_check(input stim_t b, input int p);
    if ((b.lx != ((p % W) == W - 1)) || (b.ly != (p == NPX - 1))) m_err[2] = 1'b1;
  endtask

  task automatic model_accept(input stim_t b);
    if (!m_synced) begin
      if (b.first) begin
        exp_q.push_back({b.colour, 1'b1, 1'(NPX == 1)});
        flag_check(b, 0);
        m_pos    = 1;
        m_synced = (NPX != 1);
      end else begin
        m_err[0] = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end else if (b.first) begin
      m_err[1] = 1'b1;
      m_synced = 1'b0;
      m_pos    = 0;
    end else begin
      exp_q.push_back({b.colour, 1'b0, 1'(m_pos == NPX - 1)});
      flag_check(b, m_pos);
      m_pos++;
      if (m_pos == NPX) begin
        m_pos    = 0;
        m_synced = 1'b0;
      end
    end
  endtask

  task automatic add_beat(input logic [23:0] c, input logic f, input logic lx, input logic ly);
    stim_t b;
    b.colour = c;
    b.first  = f;
    b.lx     = lx;
    b.ly     = ly;
    stim_q.push_back(b);
  endtask

  // n beats of a frame starting at pixel 0; bad_lx inverts last_x at that index.
  task automatic add_frame(input logic [23:0] base, input bit rnd, input int n, input int bad_lx);
    for (int p = 0; p < n; p++) begin
      add_beat(rnd ? 24'($urandom) : base + 24'(p), p == 0,
               ((p % W) == W - 1) ^ (p == bad_lx), p == NPX - 1);
    end
  endtask

  task automatic step();
    logic [25:0] e;
    @(negedge clk);
    if (stim_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      in_valid  = 1'b1;
      in_colour = stim_q[0].colour;
      in_first  = stim_q[0].first;
      in_last_x = stim_q[0].lx;
      in_last_y = stim_q[0].ly;
    end else begin
      in_valid  = 1'b0;
      in_colour = 24'($urandom);
      in_first  = 1'($urandom);
      in_last_x = 1'($urandom);
      in_last_y = 1'($urandom);
    end
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom);
      default: out_ready = or_pat[cycles % 4];
    endcase
    cycles++;
    #1;
    check_eq("frame_done", 32'(frame_done), 32'(fd_pending));
    if (frame_done) frames_seen++;
    check_eq("err_flags", 32'(err_flags), 32'(m_err));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
    check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (stalled) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_beat", 32'({out_data, out_sop, out_eop}), 32'(held));
    end
    fd_pending = 1'b0;
    stalled    = 1'b0;
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("out_data", 32'(out_data), 32'(e[25:2]));
      check_eq("out_sop", 32'(out_sop), 32'(e[1]));
      check_eq("out_eop", 32'(out_eop), 32'(e[0]));
      fd_pending = e[0];
    end else if (out_valid && !out_ready) begin
      stalled = 1'b1;
      held    = {out_data, out_sop, out_eop};
    end
    if (in_valid && in_ready) begin
      model_accept(stim_q.pop_front());
      accepts++;
    end
  endtask

  // Runs until all stimulus is drained, or until stop_after beats were accepted.
  task automatic run_stream(input int stop_after, input int max_cycles);
    accepts = 0;
    cycles  = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || fd_pending) &&
           (stop_after == 0 || accepts < stop_after) && cycles < max_cycles) begin
      step();
    end
    if (stop_after == 0) check_eq("stream_drained", 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_err", 32'(err_flags), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stim_q.delete();
    exp_q.delete();
    m_synced    = 1'b0;
    m_pos       = 0;
    m_err       = 3'b000;
    m_drop      = 0;
    fd_pending  = 1'b0;
    stalled     = 1'b0;
    frames_seen = 0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_colour = '0;
    in_first  = 1'b0;
    in_last_x = 1'b0;
    in_last_y = 1'b0;
    out_ready = 1'b1;
    gaps      = 1'b0;
    or_mode   = 0;
    or_pat    = 4'b1001;

    do_reset();

    // Clean frame at full rate: 8 accepts, one output cycle, one frame_done cycle.
    add_frame(24'h000001, 1'b0, NPX, -1);
    run_stream(0, 100);
    check_eq("clean_cycles", 32'(cycles), 32'd10);
    check_eq("clean_frames", 32'(frames_seen), 32'd1);
    check_eq("clean_err", 32'(err_flags), 32'd0);

    do_reset();
    for (int i = 0; i < 3; i++) add_beat(24'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    add_frame(24'h000011, 1'b0, NPX, -1);
    run_stream(0, 100);
    check_eq("orphan_drop", 32'(drop_count), 32'd3);
    check_eq("orphan_err", 32'(err_flags), 32'b001);
    check_eq("orphan_frames", 32'(frames_seen), 32'd1);

    do_reset();
    add_frame(24'h000021, 1'b0, 5, -1);
    add_beat(24'hABCDEF, 1'b1, 1'b0, 1'b0);
    add_frame(24'h000031, 1'b0, NPX, -1);
    run_stream(0, 100);
    check_eq("early_err", 32'(err_flags), 32'b010);
    check_eq("early_drop", 32'(drop_count), 32'd0);
    check_eq("early_frames", 32'(frames_seen), 32'd1);

    do_reset();
    or_mode = 2;
    add_frame(24'h000041, 1'b0, NPX, -1);
    run_stream(0, 200);
    check_eq("bp_frames", 32'(frames_seen), 32'd1);
    check_eq("bp_err", 32'(err_flags), 32'd0);
    or_mode = 0;

    do_reset();
    add_frame(24'h000051, 1'b0, NPX, 2);
    run_stream(0, 100);
    check_eq("badflag_err", 32'(err_flags), 32'b100);
    check_eq("badflag_frames", 32'(frames_seen), 32'd1);

    // Reset lands mid-frame with sticky state already set.
    do_reset();
    add_beat(24'h0000AA, 1'b0, 1'b0, 1'b0);
    add_beat(24'h0000BB, 1'b0, 1'b0, 1'b0);
    add_frame(24'h000061, 1'b0, 6, -1);
    run_stream(6, 100);
    check_eq("midrst_accepts", 32'(accepts), 32'd6);
    do_reset();
    add_frame(24'h000071, 1'b0, NPX, -1);
    run_stream(0, 100);
    check_eq("midrst_frames", 32'(frames_seen), 32'd1);
    check_eq("midrst_err", 32'(err_flags), 32'd0);

    // Randomized traffic with gaps, backpressure and injected framing faults.
    do_reset();
    gaps    = 1'b1;
    or_mode = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < $urandom_range(0, 2); i++) add_beat(24'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) add_frame(24'h0, 1'b1, $urandom_range(2, NPX - 1), -1);
      add_frame(24'h0, 1'b1, NPX, ($urandom_range(0, 5) == 0) ? $urandom_range(0, NPX - 1) : -1);
    end
    run_stream(0, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pixel_stream_packer

`default_nettype wire
